// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with a one-doubleword line buffer and loader port
module imem_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       inst_addr,
  input  logic              inst_ena,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              inst_fault,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [63:0]       load_data,
  output logic              busy
);

  typedef enum logic {IDLE, FILL} state_t;

  state_t state;
  logic [63:0] mem [0:(1<<ADDR_W)-1];
  logic [63:0] rd_data;
  logic        buf_valid;
  logic [60:0] buf_tag;
  logic [63:0] buf_data;
  logic [60:0] fill_tag;

  logic [60:0]       tag;
  logic [ADDR_W-1:0] index;
  logic              half;
  logic              misaligned;
  logic              range_err;
  logic              hit;
  logic              miss;
  logic              do_load;
  logic              do_fill;
  logic              load_hits_buf;

  assign tag        = inst_addr[63:3];
  assign index      = inst_addr[ADDR_W+2:3];
  assign half       = inst_addr[2];
  assign misaligned = |inst_addr[1:0];
  assign range_err  = |inst_addr[63:ADDR_W+3];
  assign hit        = buf_valid && (buf_tag == tag);
  assign miss       = inst_ena && !misaligned && !range_err && !hit;

  assign load_ready = (state == IDLE) && !rst;
  assign busy       = (state == FILL) && !rst;
  assign do_load    = load_valid && load_ready;
  // Loader writes win over a pending miss; the miss is retried next IDLE cycle.
  assign do_fill    = load_ready && !load_valid && miss;

  // Only a tag that could ever be buffered (upper bits zero) is invalidated.
  assign load_hits_buf = buf_valid && (buf_tag[ADDR_W-1:0] == load_addr) &&
                         (buf_tag[60:ADDR_W] == '0);

  always_comb begin
    inst       = 32'h0;
    inst_valid = 1'b0;
    inst_fault = 1'b0;
    if (!rst && inst_ena) begin
      if (misaligned || range_err) begin
        inst       = NOP_INST;
        inst_valid = 1'b1;
        inst_fault = 1'b1;
      end else if (hit) begin
        inst       = half ? buf_data[63:32] : buf_data[31:0];
        inst_valid = 1'b1;
      end
    end
  end

  // The array is never reset so loaded contents survive rst.
  always_ff @(posedge clk) begin
    if (do_load) mem[load_addr] <= load_data;
    if (do_fill) rd_data <= mem[index];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      fill_tag  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            if (load_hits_buf) buf_valid <= 1'b0;
          end else if (miss) begin
            fill_tag <= tag;
            state    <= FILL;
          end
        end
        FILL: begin
          buf_data  <= rd_data;
          buf_tag   <= fill_tag;
          buf_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - self-checking bench for imem_responder
module tb_imem_responder;

  localparam int          ADDR_W   = 10;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic [63:0]       inst_addr;
  logic              inst_ena;
  logic [31:0]       inst;
  logic              inst_valid;
  logic              inst_fault;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [63:0]       load_data;
  logic              busy;

  int checks = 0;
  int errors = 0;

  imem_responder #(.ADDR_W(ADDR_W), .NOP_INST(NOP_INST)) dut (
    .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena),
    .inst(inst), .inst_valid(inst_valid), .inst_fault(inst_fault),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as an associative array, the line buffer as
  // (valid, doubleword number, data), and a flag for a fill outstanding.
  logic [63:0] m_mem [int];
  bit          m_valid;
  logic [60:0] m_line;
  logic [63:0] m_data;
  bit          m_pending;
  logic [60:0] m_ptag;

  function automatic bit m_fault();
    return (inst_addr[1:0] != 0) || (inst_addr >= 64'(1) << (ADDR_W + 3));
  endfunction

  function automatic bit m_hit();
    return m_valid && (m_line == inst_addr >> 3);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid   = 0;
      m_pending = 0;
    end else if (m_pending) begin
      m_data    = m_mem.exists(int'(m_ptag)) ? m_mem[int'(m_ptag)] : 64'h0;
      m_line    = m_ptag;
      m_valid   = 1;
      m_pending = 0;
    end else if (load_valid) begin
      m_mem[int'(load_addr)] = load_data;
      if (m_valid && m_line == 61'(load_addr)) m_valid = 0;
    end else if (inst_ena && !m_fault() && !m_hit()) begin
      m_pending = 1;
      m_ptag    = 61'(inst_addr >> 3);
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_inst;
    logic        e_valid, e_fault;
    e_inst = 0; e_valid = 0; e_fault = 0;
    if (!rst && inst_ena) begin
      if (m_fault()) begin
        e_inst = NOP_INST; e_valid = 1; e_fault = 1;
      end else if (m_hit()) begin
        e_inst  = inst_addr[2] ? m_data[63:32] : m_data[31:0];
        e_valid = 1;
      end
    end
    check("cyc_inst", 64'(inst), 64'(e_inst));
    check("cyc_inst_valid", 64'(inst_valid), 64'(e_valid));
    check("cyc_inst_fault", 64'(inst_fault), 64'(e_fault));
    check("cyc_load_ready", 64'(load_ready), 64'(!rst && !m_pending));
    check("cyc_busy", 64'(busy), 64'(!rst && m_pending));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [63:0] d);
    load_valid = 1; load_addr = a; load_data = d;
    #1 check("load_ready_idle", 64'(load_ready), 64'd1);
    tick();
    load_valid = 0;
  endtask

  initial begin
    rst = 1; inst_ena = 0; inst_addr = 0;
    load_valid = 0; load_addr = 0; load_data = 0;
    m_valid = 0; m_pending = 0; m_line = 0; m_data = 0; m_ptag = 0;
    tick(); tick();
    check("rst_load_ready", 64'(load_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 0;

    load(0, 64'h00208093_00100093);
    load(2, 64'h11111111_22222222);
    load(5, 64'hAAAA0001_AAAA0002);
    load(7, 64'hDDDD0001_DDDD0002);

    // miss: FILL in cycle 1, data in cycle 2; then same-line hit
    inst_ena = 1; inst_addr = 64'h0;
    #1 check("miss0_valid", 64'(inst_valid), 64'd0);
    tick();
    check("miss0_busy", 64'(busy), 64'd1);
    check("miss0_c1_valid", 64'(inst_valid), 64'd0);
    tick();
    check("miss0_inst", 64'(inst), 64'h00100093);
    check("miss0_c2_valid", 64'(inst_valid), 64'd1);
    inst_addr = 64'h4;
    #1 check("hit4_inst", 64'(inst), 64'h00208093);
    check("hit4_valid", 64'(inst_valid), 64'd1);

    // faults: misaligned and out of range
    inst_addr = 64'h2;
    #1 check("mis_fault", 64'(inst_fault), 64'd1);
    check("mis_inst", 64'(inst), 64'h13);
    check("mis_valid", 64'(inst_valid), 64'd1);
    tick();
    check("mis_busy", 64'(busy), 64'd0);
    inst_addr = 64'h2000;
    #1 check("range_fault", 64'(inst_fault), 64'd1);
    check("range_inst", 64'(inst), 64'h13);
    tick();
    check("range_busy", 64'(busy), 64'd0);

    // loader write invalidates the buffered line
    inst_addr = 64'h28;
    tick(); tick();
    check("idx5_old", 64'(inst), 64'hAAAA0002);
    load_valid = 1; load_addr = 5; load_data = 64'hBBBB0001_BBBB0002;
    #1 check("idx5_hit_during_load", 64'(inst), 64'hAAAA0002);
    tick();
    load_valid = 0;
    #1 check("idx5_invalidated", 64'(inst_valid), 64'd0);
    tick(); tick();
    check("idx5_new", 64'(inst), 64'hBBBB0002);

    // load and miss in the same cycle: write first, data 3 cycles later
    inst_addr = 64'h30;
    load_valid = 1; load_addr = 6; load_data = 64'hCCCC0001_CCCC0002;
    #1 check("lm_ready", 64'(load_ready), 64'd1);
    check("lm_c0_valid", 64'(inst_valid), 64'd0);
    tick();
    load_valid = 0;
    #1 check("lm_c1_busy", 64'(busy), 64'd0);
    tick();
    check("lm_c2_busy", 64'(busy), 64'd1);
    tick();
    check("lm_c3_inst", 64'(inst), 64'hCCCC0002);
    check("lm_c3_valid", 64'(inst_valid), 64'd1);

    // reset during FILL abandons the fill; array survives
    inst_addr = 64'h38;
    tick();
    check("rf_busy", 64'(busy), 64'd1);
    rst = 1;
    #1 check("rf_rst_busy", 64'(busy), 64'd0);
    check("rf_rst_ready", 64'(load_ready), 64'd0);
    check("rf_rst_valid", 64'(inst_valid), 64'd0);
    tick();
    rst = 0;
    #1 check("rf_after_valid", 64'(inst_valid), 64'd0);
    check("rf_after_busy", 64'(busy), 64'd0);
    tick(); tick();
    check("rf_reread", 64'(inst), 64'hDDDD0002);

    // address change during FILL: buffer still tagged with captured address
    inst_addr = 64'h0;
    tick();
    inst_addr = 64'h10;
    #1 check("ac_busy", 64'(busy), 64'd1);
    tick();
    inst_addr = 64'h0;
    #1 check("ac_tag0_inst", 64'(inst), 64'h00100093);
    check("ac_tag0_valid", 64'(inst_valid), 64'd1);
    inst_addr = 64'h10;
    #1 check("ac_10_miss", 64'(inst_valid), 64'd0);
    tick();
    check("ac_10_busy", 64'(busy), 64'd1);
    tick();
    check("ac_10_inst", 64'(inst), 64'h22222222);
    check("ac_10_valid", 64'(inst_valid), 64'd1);

    inst_ena = 0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the `rvcpu` fetch port. It serves the core's `inst_addr`/`inst_ena` requests with 32-bit instructions from a 64-bit-wide synchronous-read array. A single-entry doubleword line buffer lets sequential fetches within the same doubleword complete in zero wait cycles, and a valid/ready loader port programs the array.

## Interface
- `ADDR_W`, 10: doubleword index width; the array holds 2^ADDR_W x 64 bits.
- `NOP_INST`, 32'h0000_0013: instruction returned on a fault (`addi x0,x0,0`).

- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `inst_addr` input 64 (`REG_BUS`): fetch byte address from the core.
- `inst_ena` input 1: fetch request.
- `inst` output 32: returned instruction.
- `inst_valid` output 1: `inst` is valid this cycle.
- `inst_fault` output 1: the request was misaligned or out of range; `inst` is `NOP_INST`.
- `load_valid` input 1: loader write request.
- `load_ready` output 1: loader write accepted this cycle when `load_valid` is also high.
- `load_addr` input ADDR_W: doubleword index for the loader write.
- `load_data` input 64: doubleword to write.
- `busy` output 1: a fill is in flight (state is FILL).

## Operation
- Address fields:
  - tag = `inst_addr[63:3]`
  - index = `inst_addr[ADDR_W+2:3]`
  - half = `inst_addr[2]`
  - range error = `inst_addr[63:ADDR_W+3]` is nonzero
  - misaligned = `inst_addr[1:0]` is nonzero
- State: `buf_valid`, `buf_tag[60:0]`, `buf_data[63:0]`, `fill_tag`, and FSM state IDLE or FILL.
- Outputs are combinational from the current request and the registered state:
  - `inst_ena`=0: `inst`=0, `inst_valid`=0, `inst_fault`=0.
  - Misaligned or range error: `inst`=`NOP_INST`, `inst_valid`=1, `inst_fault`=1. No fill is started. Misaligned is checked before range error; both give the same outputs.
  - Hit (`buf_valid` and `buf_tag`==tag): `inst` = `buf_data[63:32]` if half=1, else `buf_data[31:0]`. `inst_valid`=1, `inst_fault`=0.
  - Miss: `inst_valid`=0, `inst`=0.
- FSM transitions:
  - IDLE, with `load_valid`: perform the loader write (`load_ready`=1). Loader writes take priority over misses, so a pending miss waits.
  - IDLE, with a miss and no `load_valid`: issue a synchronous read of mem[index], set `fill_tag`=tag, go to FILL.
  - FILL: the read data arrives; `buf_data`=read data, `buf_tag`=`fill_tag`, `buf_valid`=1; go to IDLE unconditionally.
- `load_ready` = (state==IDLE) && !`rst`. It is 0 in FILL.
- Loader write: mem[`load_addr`] = `load_data`. If `buf_valid` and `buf_tag[ADDR_W-1:0]`==`load_addr` and the upper tag bits are 0, clear `buf_valid`.
- Address change during FILL: the fill completes with the captured `fill_tag`. The new address is then evaluated as hit or miss from the next IDLE cycle.
- The array is not reset, and contents persist across `rst`.

## Timing
- Reset, sampled on an edge with `rst`=1:
  - state=IDLE, `buf_valid`=0, `buf_tag`=0, `buf_data`=0, `fill_tag`=0.
  - While `rst`=1: `inst_valid`=0, `inst_fault`=0, `inst`=0, `load_ready`=0, `busy`=0.
- Hit and fault latency: 0 cycles; `inst_valid` in the same cycle as the request.
- Miss latency, with the request held stable:
  - cycle 0: miss, FSM goes to FILL
  - cycle 1: FILL, `busy`=1
  - cycle 2: hit, `inst_valid`=1
- Handshake: the requester holds `inst_addr` and `inst_ena` until `inst_valid`=1. A loader write completes on the edge where `load_valid` and `load_ready` are both 1.
- Reset asserted during FILL: the fill is abandoned and the buffer stays invalid.
- Loader write and fetch hit in the same cycle: the hit is served from the old `buf_data`, and `buf_valid` clears on the edge if the indices match.
- Wrap-around: the index is taken modulo 2^ADDR_W only after the range check, so any address ≥ 2^(ADDR_W+3) faults.

## Test plan
- Reset, then load mem[0]=64'h00208093_00100093; fetch 0x0 → miss, `busy`=1 in cycle 1, `inst`=32'h00100093 with `inst_valid` in cycle 2. Then fetch 0x4 → `inst`=32'h00208093 in the same cycle.
- Fetch 0x2 → `inst_fault`=1, `inst`=32'h00000013, `inst_valid`=1 in the same cycle, `busy` stays 0. Fetch 0x2000 (ADDR_W=10) → same fault response.
- Buffer holds index 5; load mem[5]=new value → `buf_valid` clears. Fetch 0x28 → misses and returns the new low word two cycles later.
- `load_valid` and a miss in the same IDLE cycle → write accepted first, FILL starts the next cycle, `inst_valid` 3 cycles after the request.
- Assert `rst` during FILL → next cycle `buf_valid`=0, state IDLE, `inst_valid`=0. The earlier loaded array contents are still readable afterwards.
- Change `inst_addr` from 0x0 to 0x10 during FILL → buffer tagged 0. Fetch 0x10 misses and completes 2 cycles later with mem[2] low word.
